// File: rtl/gal_bus_pkg.sv
// Shared types and defaults for the tristate bus read path.
package gal_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEF_TURN    = 1;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TIMEOUT = 15;

  // One spare bit so a counter can hold its own limit without wrapping.
  function automatic int cnt_w(input int lim);
    return $clog2(lim) + 1;
  endfunction

endpackage

// File: rtl/bus_settle.sv
// Bus stability filter: tracks the last sampled word and how long it has held.
import gal_bus_pkg::*;

module bus_settle #(
  parameter int W      = 4,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] b,
  output logic         stable
);

  localparam int             SW     = cnt_w(SETTLE);
  localparam logic [SW-1:0]  S_LAST = SW'(SETTLE - 1);

  logic [W-1:0]  ref_q;
  logic [SW-1:0] cnt_q;

  // Asserted on the edge where the count would reach SETTLE.
  assign stable = (b == ref_q) && (cnt_q == S_LAST);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ref_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      ref_q <= b;
      cnt_q <= '0;
    end else if (en) begin
      if (b == ref_q) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        ref_q <= b;
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/tri_bus_reader.sv
// Reads a released tristate bus via STB/ACK, with turnaround, settle filter,
// timeout/contention abort and a valid/ready output.
import gal_bus_pkg::*;

module tri_bus_reader #(
  parameter int TURN    = DEF_TURN,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int W       = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic         REQ,
  input  logic         OWN,
  input  logic [W-1:0] B,
  input  logic         ACK,
  input  logic         RDY,
  output logic         STB,
  output logic [W-1:0] Q,
  output logic         V,
  output logic         BUSY,
  output logic         AB
);

  localparam int            TW        = cnt_w(TURN);
  localparam int            OW        = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);

  state_t        state_q;
  logic [TW-1:0] turn_q;
  logic [OW-1:0] to_q;

  logic in_xfer, contend, tmo, abort;
  logic settle_clr, settle_en, stable;

  assign in_xfer    = (state_q == ST_STROBE) || (state_q == ST_SETTLE);
  assign contend    = in_xfer && OWN;
  assign tmo        = in_xfer && (to_q == TO_LAST);
  assign abort      = contend || tmo;
  assign settle_clr = (state_q == ST_STROBE) && ACK && !abort;
  assign settle_en  = (state_q == ST_SETTLE) && ACK && !abort;
  assign BUSY       = (state_q != ST_IDLE);

  bus_settle #(.W(W), .SETTLE(SETTLE)) u_settle (
    .gclk   (C),
    .grst_n (R),
    .clr    (settle_clr),
    .en     (settle_en),
    .b      (B),
    .stable (stable)
  );

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      turn_q  <= '0;
      to_q    <= '0;
      STB     <= 1'b0;
      Q       <= '0;
      V       <= 1'b0;
      AB      <= 1'b0;
    end else begin
      AB <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            state_q <= ST_TURN;
            turn_q  <= '0;
          end
        end
        ST_TURN: begin
          if (OWN) begin
            turn_q <= '0;
          end else begin
            turn_q <= turn_q + 1'b1;
            if (turn_q == TURN_LAST) begin
              state_q <= ST_STROBE;
              STB     <= 1'b1;
              to_q    <= '0;
            end
          end
        end
        ST_STROBE, ST_SETTLE: begin
          // Contention and timeout both win over capture.
          if (abort) begin
            AB      <= 1'b1;
            STB     <= 1'b0;
            V       <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
            if (state_q == ST_STROBE) begin
              if (ACK) state_q <= ST_SETTLE;
            end else if (!ACK) begin
              state_q <= ST_STROBE;
            end else if (stable) begin
              Q       <= B;
              V       <= 1'b1;
              STB     <= 1'b0;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (RDY) begin
            V       <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
